// File: rtl/mult8s_dot_accum.sv
// mult8s_dot_accum
// Accumulates the signed product stream from the 8x8 multiplier wrapper
// into per-frame dot-product sums. A frame ends on in_last or after
// MAX_LEN beats. The result is presented on a valid/ready port, and the
// input stalls until the result is taken.
//
// Build option: define MULT_DOT_ACCUM_SAT_EN to make the accumulator clamp
// on signed overflow. Without it, the accumulator wraps modulo 2^ACC_W.
// out_overflow behaves the same in both builds.

module mult8s_dot_accum #(
    parameter  int PROD_W  = 16,
    parameter  int ACC_W   = 32,
    parameter  int MAX_LEN = 256,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [PROD_W-1:0] product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_overflow
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);
`ifdef MULT_DOT_ACCUM_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf;

    logic                     accept;
    logic                     frame_end;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum_raw;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     ovf_now;

    // Next accumulator value and overflow flag for the beat on the input.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so that no
        // path through the block leaves it unassigned and infers a latch.
        prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
        sum_raw  = acc + prod_ext;
        // Overflow: the operands share a sign and the raw sum's sign differs.
        ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != acc[ACC_W-1]);
        acc_next = sum_raw;
`ifdef MULT_DOT_ACCUM_SAT_EN
        // A negative acc can only overflow downward; a positive acc can only overflow upward.
        if (ovf_now) begin
            acc_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    assign accept    = in_valid && in_ready;
    assign frame_end = in_last || (cnt == CNT_LAST);

    // Frame state machine: accumulate beats, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // flop samples the values from before the edge, whatever order the
        // statements are written in.
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        ovf <= ovf | ovf_now;
                        if (frame_end) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // The handshake signals come straight from the state flop. The result
    // outputs are the registered totals, which stay frozen while in HOLD.
    assign in_ready     = (state == ACCUM);
    assign out_valid    = (state == HOLD);
    assign out_sum      = acc;
    assign out_count    = cnt;
    assign out_overflow = ovf;

endmodule

// File: doc/mult8s_dot_accum.md
# mult8s_dot_accum

Downstream consumer of the registered signed 8x8 multiplier wrapper's 16-bit product stream. It accumulates sign-extended products into a wide accumulator, frame by frame, to form a dot product. A frame ends on an explicit last beat or when a beat count limit is reached. Each finished sum, its beat count and an overflow flag are presented on a valid/ready output port with backpressure.

## Interface
- PROD_W, 16: product width, two's complement; matches the wrapper's product output.
- ACC_W, 32: accumulator and result width; must be ≥ PROD_W+1.
- MAX_LEN, 256: maximum beats per frame; a frame auto-terminates on beat MAX_LEN.
- CNT_W, $clog2(MAX_LEN+1): beat counter width; derived, not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  product beat valid; driven by the caller's valid pipeline, aligned to the wrapper's 2-cycle latency.
- in_ready  out  1  block accepts a beat this cycle.
- in_last  in  1  beat is the final one of the frame; qualified by in_valid.
- product  in  PROD_W  signed product from the wrapper.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  signed frame sum.
- out_count  out  CNT_W  beats in the frame, 1..MAX_LEN.
- out_overflow  out  1  signed overflow occurred at least once in the frame (sticky).

## Operation
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready.
- On each accepted beat:
  - acc <= acc + sext(product, ACC_W).
  - cnt <= cnt + 1.
  - ovf <= ovf | signed_overflow(acc, sext(product)).
- Frame end: an accepted beat with in_last=1, or with cnt==MAX_LEN-1 before the increment.
  - That beat is accumulated first.
  - The state then moves to HOLD.
  - out_sum, out_count and out_overflow are the registered acc, cnt and ovf after that beat.
- HOLD with out_ready=1:
  - acc, cnt and ovf clear to 0.
  - State returns to ACCUM.
- HOLD with out_ready=0:
  - All outputs are held stable.
  - in_ready stays 0; the upstream must stall.
- in_last on a non-accepted cycle is ignored.
- Overflow detection: operands have the same sign and the raw sum's sign differs. The result depends on SAT (see Configuration).
- A result is never emitted for an empty frame. The count is always ≥1.

## Timing
- Reset (rst_n=0 at a rising edge):
  - State ACCUM, acc=0, cnt=0, ovf=0.
  - in_ready=1, out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - Reset mid-frame or in HOLD discards all partial state, and any pending result is dropped.
- Accumulate throughput: one beat per cycle in ACCUM.
- Latency: the last beat is accepted at edge N and out_valid=1 from edge N (visible in cycle N+1).
- Earliest out_ready handshake: cycle N+1. in_ready returns in cycle N+2, giving one bubble per frame minimum.
- Outputs are fully registered. in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- Operand-to-result latency from the wrapper's operand inputs is wrapper latency (2) + frame length + 1 cycle.

## Configuration
- MULT_DOT_ACCUM_SAT_EN defined:
  - On overflow, acc clamps to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow).
  - Subsequent beats continue from the clamped value.
- MULT_DOT_ACCUM_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W.
- out_overflow is reported identically in both builds.

## Test plan
- **Basic frame:** after reset, beats 3, -5, 127 (last) → in_ready=1 throughout. out_valid the cycle after the third beat, with out_sum=125, out_count=3, out_overflow=0.
- **Backpressure:** frame ends while out_ready=0 for 5 cycles → out_valid and outputs stable, in_ready=0 for all 5 cycles. After out_ready=1, one cycle later in_ready=1 and acc=0.
- **Auto-termination:** MAX_LEN=4, four beats of 16'sh4000 with in_last=0 → out_count=4, out_sum=65536.
- **Overflow:** ACC_W=17, beats 16'sh7FFF (32767), 16'sh7FFF, 16'sh7FFF (last):
  - With SAT: out_sum=65535, out_overflow=1.
  - Without SAT: out_sum=17'h17FFD (-32771), out_overflow=1.
  - Next frame of a single beat 1 gives out_overflow=0.
- **Reset mid-frame:** two beats accepted, rst_n=0 for one edge → all outputs 0. A following single-beat frame of -1 (last) gives out_sum=-1, out_count=1.
- **Idle bubbles:** in_valid toggled 1,0,1,0,1 (last) with products 2,2,2 → only valid beats counted: out_count=3, out_sum=6.
